// File: rtl/key_tx_ctrl.sv
// Two debounced push buttons turned into UART toggle commands for two remote LEDs.
// tx_start fires two cycles after a key's pending flag is set, provided the UART is idle.
module key_tx_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key1,
    input  logic       key2,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       led1_state,
    output logic       led2_state
);
    localparam int DEB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CW         = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t     state;
    logic [1:0] keys;
    logic [1:0] sync0;
    logic [1:0] sync1;
    logic [1:0] deb;
    logic [1:0] deb_d;
    logic [1:0] press;
    logic [1:0] pend;
    logic [1:0] clr;
    logic       sel;
    logic [3:0] wb_cnt;

    assign keys  = {key2, key1};
    assign press = deb_d & ~deb;

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync0[i] <= 1'b1;
                sync1[i] <= 1'b1;
                deb[i]   <= 1'b1;
                deb_d[i] <= 1'b1;
                cnt      <= '0;
            end else begin
                sync0[i] <= keys[i];
                sync1[i] <= sync0[i];
                deb_d[i] <= deb[i];
                if (sync1[i] == deb[i]) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= sync1[i];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Key1 wins when both are pending; a fresh press in the clearing cycle re-arms the flag.
    always_comb begin
        clr = 2'b00;
        if (state == IDLE && !tx_busy && |pend)
            clr = pend[0] ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= 2'b00;
        else
            pend <= press | (pend & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
            led1_state <= 1'b0;
            led2_state <= 1'b0;
            sel        <= 1'b0;
            wb_cnt     <= 4'd0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pend && !tx_busy) begin
                        sel <= ~pend[0];
                        if (pend[0])
                            tx_data <= led1_state ? 8'h05 : 8'h03;
                        else
                            tx_data <= led2_state ? 8'h06 : 8'h04;
                        state <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    if (sel)
                        led2_state <= ~led2_state;
                    else
                        led1_state <= ~led1_state;
                    wb_cnt <= 4'd0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Give up after 16 cycles without busy; the command is not retried.
                    if (tx_busy)
                        state <= WAIT_DONE;
                    else if (wb_cnt == 4'd15)
                        state <= IDLE;
                    else
                        wb_cnt <= wb_cnt + 4'd1;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_tx_ctrl.sv
// Scoreboarded bench for key_tx_ctrl with a small uart_tx busy model.
module tb_key_tx_ctrl;
    typedef struct {
        logic [7:0] data;
        logic       led1;
        logic       led2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key1 = 1'b1;
    logic       key2 = 1'b1;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       led1_state;
    logic       led2_state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic tie_idle = 1'b0;
    int   last_start = 0;
    int   prev_start = 0;
    exp_t sb[$];

    key_tx_ctrl #(.CLK_FREQ(1000), .DEBOUNCE_MS(4)) dut (
        .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start),
        .led1_state(led1_state), .led2_state(led2_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start && !tie_idle)
            busy_cnt <= 20;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0) && !tie_idle;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every tx_start must match the oldest queued command.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            exp_t e;
            prev_start = last_start;
            last_start = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_start: got tx_data=%0h expected no start (cycle %0d)", tx_data, cyc);
            end else begin
                e = sb.pop_front();
                check("tx_data", tx_data, e.data);
                check("led1_state", led1_state, e.led1);
                check("led2_state", led2_state, e.led2);
                check("busy_at_start", tx_busy, 0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_keys(input logic k1, input logic k2, input int n);
        @(negedge clk);
        key1 = k1;
        key2 = k2;
        wait_cycles(n);
        key1 = 1'b1;
        key2 = 1'b1;
    endtask

    task automatic expect_cmd(input logic [7:0] d, input logic l1, input logic l2);
        exp_t e;
        e.data = d;
        e.led1 = l1;
        e.led2 = l2;
        sb.push_back(e);
    endtask

    task automatic drained(input string name);
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tx_start"}, tx_start, 0);
        check({name, "_tx_data"}, tx_data, 8'h00);
        check({name, "_led1"}, led1_state, 0);
        check({name, "_led2"}, led2_state, 0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);

        // Clean key1 press, then a second press toggling back.
        expect_cmd(8'h03, 1, 0);
        hold_keys(0, 1, 10);
        wait_cycles(60);
        drained("key1_first");
        check("led1_after_first", led1_state, 1);

        expect_cmd(8'h05, 0, 0);
        hold_keys(0, 1, 10);
        wait_cycles(60);
        drained("key1_second");

        // Bouncy key2: bursts never last long enough to count.
        expect_cmd(8'h04, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) key2 = 1'b0;
            @(negedge clk);
            @(negedge clk) key2 = 1'b1;
        end
        @(negedge clk) key2 = 1'b0;
        wait_cycles(10);
        key2 = 1'b1;
        wait_cycles(60);
        drained("key2_bounce");

        expect_cmd(8'h06, 0, 0);
        hold_keys(1, 0, 10);
        wait_cycles(60);
        drained("key2_off");

        // Simultaneous presses: key1 first, key2 after busy falls.
        expect_cmd(8'h03, 1, 0);
        expect_cmd(8'h04, 1, 1);
        hold_keys(0, 0, 10);
        wait_cycles(80);
        drained("both_keys");
        check("both_gap_after_busy", (last_start - prev_start) > 21, 1);

        // UART never answers: timeout after 16 cycles, then the key2 command follows.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("idle_reset");
        wait_cycles(2);
        rst_n = 1'b1;
        tie_idle = 1'b1;
        expect_cmd(8'h03, 1, 0);
        expect_cmd(8'h04, 1, 1);
        hold_keys(0, 0, 10);
        wait_cycles(80);
        drained("busy_tied_low");
        check("timeout_gap", last_start - prev_start, 18);
        tie_idle = 1'b0;
        wait_cycles(5);

        // Reset in the middle of a frame abandons everything.
        expect_cmd(8'h05, 0, 1);
        hold_keys(0, 1, 10);
        begin
            int n = 0;
            while (!tx_busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("busy_seen_timeout", n < 100, 1);
        end
        wait_cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(60);
        drained("after_mid_reset");
        check_reset_outputs("no_start_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_tx_ctrl.md
KEY_TX_CTRL -- requirements
Module: key_tx_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, key stable time in ms; DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key1  input  1  push button 1, active-low, asynchronous to clk.
REQ-006 key2  input  1  push button 2, active-low, asynchronous to clk.
REQ-007 tx_busy  input  1  uart_tx busy flag, high while a frame is shifting out.
REQ-008 tx_data  output  8  command byte presented to uart_tx.
REQ-009 tx_start  output  1  one-cycle pulse requesting uart_tx to send tx_data.
REQ-010 led1_state  output  1  last commanded state of remote LED1.
REQ-011 led2_state  output  1  last commanded state of remote LED2.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer (reset value 1) before any other use.
REQ-013 Each key SHALL have an independent debouncer: counter clears whenever synchronized level equals debounced level; debounced level takes synchronized level when level differs for DEB_CYCLES consecutive cycles.
REQ-014 Press event = debounced level 1->0 transition, one cycle wide; release SHALL generate no event.
REQ-015 Press event SHALL set that key's pending flag; press while pending already set SHALL be dropped (no counting).
REQ-016 Command encoding: key1 -> 0x03 if led1_state=0, else 0x05; key2 -> 0x04 if led2_state=0, else 0x06.
REQ-017 FSM states IDLE, START, WAIT_BUSY, WAIT_DONE; reset state IDLE.
REQ-018 IDLE: if any pending flag and tx_busy=0, load tx_data per REQ-016, clear that pending flag, go START; key1 has priority when both pending.
REQ-019 START: tx_start=1 for exactly this one cycle, toggle the selected ledN_state, go WAIT_BUSY.
REQ-020 WAIT_BUSY: stay until tx_busy=1, then WAIT_DONE; if tx_busy not seen within 16 cycles, return to IDLE (no retry).
REQ-021 WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go IDLE.
REQ-022 tx_data SHALL hold its value from START until next load; only changes in IDLE transition.
REQ-023 Latency: pending flag set in cycle N with FSM in IDLE and tx_busy=0 -> tx_start high in cycle N+2.
REQ-024 Press event arriving in same cycle the FSM clears that key's pending flag SHALL re-set the flag (event wins).
REQ-025 Press events SHALL be captured in every FSM state, including during an active transmission.
REQ-026 No tx_start SHALL be issued while tx_busy=1.

Reset
REQ-027 rst_n low SHALL asynchronously force: FSM IDLE, tx_start 0, tx_data 0x00, led1_state 0, led2_state 0, pending flags 0, debounced levels 1, counters 0, synchronizers 1.
REQ-028 Reset asserted mid-transmission SHALL abandon the command; no tx_start after release until a new press completes debounce.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4 -> DEB_CYCLES=4; uart_tx model raises busy 1 cycle after tx_start, holds 20 cycles)
REQ-029 key1 low held 10 cycles, led1_state=0 -> single tx_start, tx_data=0x03, led1_state=1.
REQ-030 key1 second clean press -> tx_data=0x05, led1_state=0; release generates no byte.
REQ-031 key2 bounce (low 2 cycles, high 1, repeated 5 times) then held low -> exactly one byte 0x04.
REQ-032 key1 and key2 debounced same cycle -> 0x03 sent, then 0x04 after busy falls; two tx_start pulses, never while busy.
REQ-033 Tie tx_busy=0 after key1 press -> tx_start once, FSM returns IDLE after 16 cycles, led1_state=1, no retry.
REQ-034 rst_n pulsed low during WAIT_DONE -> all outputs at reset values immediately, no tx_start until new press.
